// File: rtl/mtl2_key_debounce.sv
// mtl2_key_debounce: Avalon-MM key/PIO input block.
// Each key is synchronised, debounced and edge-detected. Edges are captured
// into a write-1-to-clear register that drives a maskable level interrupt.
module mtl2_key_debounce #(
    parameter int unsigned      WIDTH           = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter is at least one bit wide so DEBOUNCE_CYCLES=1 still elaborates.
    localparam int unsigned    CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_RISE_EN  = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_FALL_EN  = 3'd4,
        ADDR_RAW      = 3'd5
    } reg_addr_e;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;

    // Upper write-data bits beyond WIDTH are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        zext = '0;
        zext[WIDTH-1:0] = v;
    endfunction

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    // Synchroniser chain and one-cycle delay of the stable level.
    always_comb begin
        sync1_d      = in_port;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
    end

    // Per-bit debounce: stable follows sync2 only after DEBOUNCE_CYCLES of disagreement.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '{default: '0};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Edge detection, capture with set-over-clear priority, and control register writes.
    always_comb begin
        rise       = stable_q & ~stable_dly_q;
        fall       = ~stable_q & stable_dly_q;
        cap_set    = (rise & rise_en_q) | (fall & fall_en_q);
        cap_clr    = (wr_en && (address == ADDR_EDGE_CAP)) ? wdata : '0;
        edge_cap_d = cap_set | (edge_cap_q & ~cap_clr);
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en_d  = wdata;
                ADDR_IRQ_MASK: irq_mask_d = wdata;
                ADDR_FALL_EN:  fall_en_d  = wdata;
                default: ;
            endcase
        end
    end

    // Read mux, registered every cycle; reads have no side effects.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = zext(stable_q);
            ADDR_RISE_EN:  readdata_d = zext(rise_en_q);
            ADDR_IRQ_MASK: readdata_d = zext(irq_mask_q);
            ADDR_EDGE_CAP: readdata_d = zext(edge_cap_q);
            ADDR_FALL_EN:  readdata_d = zext(fall_en_q);
            ADDR_RAW:      readdata_d = zext(sync2_q);
            default:       readdata_d = '0;
        endcase
    end

    // State registers; the input path resets to the idle level so reset never creates an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= IDLE_LEVEL;
            sync2_q      <= IDLE_LEVEL;
            stable_q     <= IDLE_LEVEL;
            stable_dly_q <= IDLE_LEVEL;
            cnt_q        <= '{default: '0};
            rise_en_q    <= '0;
            fall_en_q    <= '1;
            irq_mask_q   <= '0;
            edge_cap_q   <= '0;
            readdata_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_mask_q   <= irq_mask_d;
            edge_cap_q   <= edge_cap_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_mtl2_key_debounce.sv
// Bench for mtl2_key_debounce (WIDTH=2, DEBOUNCE_CYCLES=4): directed scenarios
// plus randomized traffic, all compared against a cycle-level reference model.
module tb_mtl2_key_debounce;

    localparam int W = 2;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0]  m_s1, m_s2, m_stable, m_stable_prev;
    logic [W-1:0]  m_rise, m_fall, m_mask, m_cap;
    logic [W-1:0]  m_hist [D];   // most recent D sync2 samples, [0] newest
    logic [31:0]   m_rd;
    logic          m_irq;

    mtl2_key_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .IDLE_LEVEL      (2'b11)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    // A level becomes stable once the last D synchronised samples all disagree with it.
    task automatic model_edge();
        logic [W-1:0] new_stable;
        logic [W-1:0] set_v;
        logic [W-1:0] clr_v;
        logic         wr;
        logic         all_diff;
        if (!reset_n) begin
            m_s1 = '1; m_s2 = '1; m_stable = '1; m_stable_prev = '1;
            m_rise = '0; m_fall = '1; m_mask = '0; m_cap = '0; m_rd = '0;
            for (int i = 0; i < D; i++) m_hist[i] = '1;
        end else begin
            for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_s2;
            new_stable = m_stable;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int i = 0; i < D; i++)
                    if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) new_stable[b] = ~m_stable[b];
            end
            set_v = (m_stable & ~m_stable_prev & m_rise) | (~m_stable & m_stable_prev & m_fall);
            wr    = chipselect && !write_n;
            clr_v = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
            case (address)
                3'd0:    m_rd = {30'b0, m_stable};
                3'd1:    m_rd = {30'b0, m_rise};
                3'd2:    m_rd = {30'b0, m_mask};
                3'd3:    m_rd = {30'b0, m_cap};
                3'd4:    m_rd = {30'b0, m_fall};
                3'd5:    m_rd = {30'b0, m_s2};
                default: m_rd = '0;
            endcase
            m_cap = set_v | (m_cap & ~clr_v);
            if (wr) begin
                if (address == 3'd1) m_rise = writedata[W-1:0];
                if (address == 3'd2) m_mask = writedata[W-1:0];
                if (address == 3'd4) m_fall = writedata[W-1:0];
            end
            m_stable_prev = m_stable;
            m_stable      = new_stable;
            m_s2          = m_s1;
            m_s1          = in_port;
        end
        m_irq = |(m_cap & m_mask);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("readdata", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        step();
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 2'b11;
        step();
        step();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // Reset values of every address
        bus_read(3'd0, 32'h3, "rst_data");
        bus_read(3'd1, 32'h0, "rst_rise_en");
        bus_read(3'd2, 32'h0, "rst_irq_mask");
        bus_read(3'd3, 32'h0, "rst_edge_cap");
        bus_read(3'd4, 32'h3, "rst_fall_en");
        bus_read(3'd5, 32'h3, "rst_raw");
        bus_read(3'd6, 32'h0, "rst_addr6");
        check("rst_irq_idle", {31'b0, irq}, 32'h0);

        // Key 0 press: capture and irq exactly at edge k+6
        bus_write(3'd2, 32'h1);
        address = 3'd0;
        in_port = 2'b10;
        repeat (6) step();
        check("press_irq_early", {31'b0, irq}, 32'h0);
        check("press_data_early", readdata, 32'h3);
        step();
        check("press_irq", {31'b0, irq}, 32'h1);
        check("press_data", readdata, 32'h2);
        bus_read(3'd3, 32'h1, "press_cap");

        // 3-cycle glitch on key 1 is rejected but visible on RAW
        do_reset();
        address = 3'd5;
        in_port = 2'b01;
        repeat (3) step();
        check("glitch_raw", readdata, 32'h1);
        in_port = 2'b11;
        repeat (8) step();
        bus_read(3'd0, 32'h3, "glitch_data");
        bus_read(3'd3, 32'h0, "glitch_cap");

        // Rising-only capture on key 1
        bus_write(3'd1, 32'h2);
        bus_write(3'd4, 32'h0);
        in_port = 2'b01;
        repeat (8) step();
        bus_read(3'd3, 32'h0, "rise_only_press");
        in_port = 2'b11;
        repeat (8) step();
        bus_read(3'd3, 32'h2, "rise_only_release");

        // W1C of a single bit, then set/clear collision
        do_reset();
        in_port = 2'b00;
        repeat (8) step();
        bus_read(3'd3, 32'h3, "cap_both");
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, 32'h2, "w1c_bit0");
        bus_write(3'd1, 32'h1);
        address = 3'd0;
        in_port = 2'b01;
        repeat (6) step();
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, 32'h3, "set_wins");

        // Reset while the bit-0 counter is at 2
        do_reset();
        in_port = 2'b10;
        repeat (4) step();
        reset_n = 1'b0;
        in_port = 2'b11;
        step();
        reset_n = 1'b1;
        repeat (10) step();
        bus_read(3'd0, 32'h3, "rst_mid_data");
        bus_read(3'd3, 32'h0, "rst_mid_cap");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int op;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 5) == 0)
                in_port = in_port ^ 2'($urandom_range(1, 3));
            op = int'($urandom_range(0, 5));
            address = 3'($urandom_range(0, 7));
            writedata = $urandom;
            if (op == 0) begin
                chipselect = 1'b1; write_n = 1'b0;
            end else if (op == 1) begin
                chipselect = 1'b0; write_n = 1'b0;
            end else begin
                chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
            end
            step();
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mtl2_key_debounce.md
# mtl2_key_debounce

Parametrised Avalon-MM key/PIO input block for the MTL2 painter system: WIDTH push-button inputs are synchronised, debounced per bit, and edge-detected with per-bit rising and falling enables. Captured edges raise a maskable level interrupt toward the Nios II. It replaces the fixed 2-bit, falling-edge-only key port and adds write-1-to-clear capture so one bit can be acknowledged without losing events on other bits.

## Interface
- WIDTH, 2: number of key inputs, legal range 1..32.
- DEBOUNCE_CYCLES, 50000: cycles a synchronised input must differ from the stable level before the stable level changes (1 ms at 50 MHz). Legal range 1..2^20.
- IDLE_LEVEL, {WIDTH{1'b1}}: reset value of the synchronisers and stable level (keys idle high).

- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  raw asynchronous key inputs.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  level interrupt, OR of (edge_capture & irq_mask).

## Operation
- Register map:
  - 0 DATA, RO: debounced stable level.
  - 1 RISE_EN, RW: per-bit rising-edge capture enable. Reset 0.
  - 2 IRQ_MASK, RW: per-bit interrupt mask. Reset 0.
  - 3 EDGE_CAP, R/W1C: captured edges. Writing 1 clears a bit; writing 0 leaves it unchanged. Reset 0.
  - 4 FALL_EN, RW: per-bit falling-edge capture enable. Reset all ones, which gives key-press capture by default.
  - 5 RAW, RO: second synchroniser stage (sync2).
  - 6 and 7: read 0; writes ignored.
- Synchroniser: two flops per bit (sync1, sync2), both reset to IDLE_LEVEL.
- Debounce: one counter per bit, width clog2(DEBOUNCE_CYCLES).
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets cnt and produces no change.
- Edge detection:
  - stable_d is stable delayed one cycle; it resets to IDLE_LEVEL, so reset never produces a spurious edge.
  - rise = stable & ~stable_d; fall = ~stable & stable_d.
  - set = (rise & RISE_EN) | (fall & FALL_EN).
- Capture update per bit: if set, the bit is 1. Else if a W1C write has a 1 in that bit, the bit is 0. Else it holds. When set and clear coincide, set wins and no event is lost.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers, so there is no glitch from the bus.
- Write decode: chipselect & ~write_n. Reads have no side effects.

## Timing
- Read latency: readdata is registered every cycle from the address mux, so data is valid one clk after address is presented. Readdata is 0 during reset.
- Reset values: readdata 0, irq 0, every internal register as listed above.
- Input path: if in_port changes and is held from before edge k, then:
  - sync2 changes at edge k+1.
  - stable changes at edge k+1+DEBOUNCE_CYCLES.
  - EDGE_CAP bit and irq assert at edge k+2+DEBOUNCE_CYCLES.
- A RISE_EN, FALL_EN or IRQ_MASK write takes effect on the next edge. An IRQ_MASK write changes irq in the same cycle its register updates.
- Asserting reset mid-debounce clears the counters and forces stable to IDLE_LEVEL. No capture results.
- A counter wrap at DEBOUNCE_CYCLES-1 is exact; with DEBOUNCE_CYCLES=1 a change is accepted on the first cycle sync2 differs from stable.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=2.
- Reset, then read each address: DATA=0x3, RISE_EN=0, IRQ_MASK=0, EDGE_CAP=0, FALL_EN=0x3, RAW=0x3, address 6=0; irq=0.
- Drive in_port[0] to 0 from before edge k with IRQ_MASK=0x1 → DATA bit 0 reads 0 from edge k+5; EDGE_CAP=0x1 and irq=1 at edge k+6.
- Drive a 3-cycle low pulse on in_port[1] → DATA stays 0x3, EDGE_CAP stays 0, RAW shows the pulse.
- Set RISE_EN=0x2 and FALL_EN=0, press then release key 1 → EDGE_CAP=0x2 only after release.
- Capture bits 0 and 1, then write EDGE_CAP=0x1 → EDGE_CAP=0x2. Repeat with a new bit-0 edge landing in the same cycle as the clear write → EDGE_CAP keeps bit 0 set.
- Assert reset_n low for 1 cycle while the bit-0 counter is at 2 → after reset DATA=0x3, EDGE_CAP=0, and no edge is ever captured for that event.
